// File: rtl/wishbone_master_bus_if.sv
// -----------------------------------------------------------------------------
// wishbone_master_bus_if
//   CPU-side Wishbone classic initiator. Each pipeline memory request
//   (ce/we/addr/data/sel) becomes exactly one single Wishbone cycle. The
//   pipeline is stalled until the slave acknowledges. If the pipeline is still
//   held by another stall source when the ack arrives, the read data is parked
//   in a buffer (WAIT_STALL) until the pipeline is released.
//
//   Optional feature macro: WB_MASTER_TIMEOUT_EN
//     defined   : a cycle is aborted after TIMEOUT_CYCLES BUSY cycles without
//                 ack, and bus_err_o pulses for one cycle.
//     undefined : BUSY waits for ack indefinitely, and bus_err_o is constant 0.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   cpu_ce_i/we_i/addr_i/data_i/sel_i   request from the pipeline
//   cpu_data_o                    read data returned to the pipeline
//   cpu_stall_i                   pipeline held by another stall source
//   flush_i                       pipeline flush (exception)
//   stall_req_o                   combinational stall request to the pipeline
//   bus_err_o                     one-cycle timeout pulse
//   wishbone_*_o                  registered Wishbone master outputs
//   wishbone_data_i/ack_i         slave read data and acknowledge
// -----------------------------------------------------------------------------
module wishbone_master_bus_if #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SEL_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_ce_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_data_i,
  input  logic [SEL_WIDTH-1:0]  cpu_sel_i,
  output logic [DATA_WIDTH-1:0] cpu_data_o,
  input  logic                  cpu_stall_i,
  input  logic                  flush_i,
  output logic                  stall_req_o,
  output logic                  bus_err_o,
  output logic                  wishbone_cyc_o,
  output logic                  wishbone_stb_o,
  output logic                  wishbone_we_o,
  output logic [ADDR_WIDTH-1:0] wishbone_addr_o,
  output logic [DATA_WIDTH-1:0] wishbone_data_o,
  output logic [SEL_WIDTH-1:0]  wishbone_sel_o,
  input  logic [DATA_WIDTH-1:0] wishbone_data_i,
  input  logic                  wishbone_ack_i
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rd_buf_q;
  logic                  launch;      // start a cycle on the next edge
  logic                  bus_end;     // drop cyc/stb on the next edge
  logic                  timeout_hit; // BUSY has waited too long for ack

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt_q;

  // The count equals the number of ack-less BUSY cycles already completed,
  // so it reads TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (launch) begin
      tmo_cnt_q <= '0;
    end else if (state_q == BUSY && !wishbone_ack_i) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == BUSY) && !wishbone_ack_i &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Flush outranks ack, and ack outranks timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (cpu_ce_i && !flush_i) state_d = BUSY;
      BUSY: begin
        if (flush_i)             state_d = IDLE;
        else if (wishbone_ack_i) state_d = cpu_stall_i ? WAIT_STALL : IDLE;
        else if (timeout_hit)    state_d = IDLE;
      end
      WAIT_STALL: if (!cpu_stall_i || flush_i) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Output logic. The pipeline-facing outputs are combinational, so the ack
  // cycle itself releases the stall and presents the read data.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    stall_req_o = 1'b0;
    cpu_data_o  = '0;
    bus_err_o   = 1'b0;
    launch      = 1'b0;
    bus_end     = 1'b0;
    unique case (state_q)
      IDLE: begin
        launch      = cpu_ce_i && !flush_i;
        stall_req_o = launch;
      end
      BUSY: begin
        if (flush_i) begin
          bus_end = 1'b1;
        end else if (wishbone_ack_i) begin
          bus_end    = 1'b1;
          cpu_data_o = wishbone_we_o ? '0 : wishbone_data_i;
        end else if (timeout_hit) begin
          bus_end   = 1'b1;
          bus_err_o = 1'b1;
        end else begin
          stall_req_o = 1'b1;
        end
      end
      WAIT_STALL: cpu_data_o = rd_buf_q;
      default: ;
    endcase
  end

  // Registered Wishbone outputs: latched at launch, held through BUSY and
  // cleared together when the cycle ends for any reason, so cyc == stb always.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wishbone_cyc_o  <= 1'b0;
      wishbone_stb_o  <= 1'b0;
      wishbone_we_o   <= 1'b0;
      wishbone_addr_o <= '0;
      wishbone_data_o <= '0;
      wishbone_sel_o  <= '0;
    end else if (launch) begin
      wishbone_cyc_o  <= 1'b1;
      wishbone_stb_o  <= 1'b1;
      wishbone_we_o   <= cpu_we_i;
      wishbone_addr_o <= cpu_addr_i;
      wishbone_data_o <= cpu_data_i;
      wishbone_sel_o  <= cpu_sel_i;
    end else if (bus_end) begin
      wishbone_cyc_o  <= 1'b0;
      wishbone_stb_o  <= 1'b0;
      wishbone_we_o   <= 1'b0;
      wishbone_addr_o <= '0;
      wishbone_data_o <= '0;
      wishbone_sel_o  <= '0;
    end
  end

  // Read buffer that feeds WAIT_STALL. A write ack stores 0, so a stalled
  // write never returns stale read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_buf_q <= '0;
    end else if (state_q == BUSY && wishbone_ack_i && !flush_i) begin
      rd_buf_q <= wishbone_we_o ? '0 : wishbone_data_i;
    end
  end

endmodule

// File: tb/tb_wishbone_master_bus_if.sv
// -----------------------------------------------------------------------------
// tb_wishbone_master_bus_if
//   Self-checking bench for wishbone_master_bus_if. Each request is described
//   as a transaction: ack delay, flush point and post-ack stall length. The
//   expected cycle-by-cycle bus and pipeline behaviour is derived from that
//   description.
// -----------------------------------------------------------------------------
module tb_wishbone_master_bus_if;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 4;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_ce_i = 1'b0;
  logic          cpu_we_i = 1'b0;
  logic [AW-1:0] cpu_addr_i = '0;
  logic [DW-1:0] cpu_data_i = '0;
  logic [SW-1:0] cpu_sel_i = '0;
  logic [DW-1:0] cpu_data_o;
  logic          cpu_stall_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          stall_req_o;
  logic          bus_err_o;
  logic          wishbone_cyc_o, wishbone_stb_o, wishbone_we_o;
  logic [AW-1:0] wishbone_addr_o;
  logic [DW-1:0] wishbone_data_o;
  logic [SW-1:0] wishbone_sel_o;
  logic [DW-1:0] wishbone_data_i = '0;
  logic          wishbone_ack_i = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  wishbone_master_bus_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .cpu_stall_i(cpu_stall_i), .flush_i(flush_i),
    .stall_req_o(stall_req_o), .bus_err_o(bus_err_o),
    .wishbone_cyc_o(wishbone_cyc_o), .wishbone_stb_o(wishbone_stb_o),
    .wishbone_we_o(wishbone_we_o), .wishbone_addr_o(wishbone_addr_o),
    .wishbone_data_o(wishbone_data_o), .wishbone_sel_o(wishbone_sel_o),
    .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare the whole Wishbone master output set against one expected tuple.
  task automatic check_wb(input string tag, input bit cyc, input bit we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] sel);
    check({tag, ".cyc"},  wishbone_cyc_o,  cyc);
    check({tag, ".stb"},  wishbone_stb_o,  cyc);
    check({tag, ".we"},   wishbone_we_o,   we);
    check({tag, ".addr"}, wishbone_addr_o, addr);
    check({tag, ".data"}, wishbone_data_o, data);
    check({tag, ".sel"},  wishbone_sel_o,  sel);
  endtask

  // Quiet CPU side for one cycle; the slave may send a stray ack.
  task automatic idle_cycle(input string tag, input bit stray_ack);
    @(negedge clk);
    cpu_ce_i = 1'b0; flush_i = 1'b0; cpu_stall_i = 1'b0;
    wishbone_ack_i = stray_ack; wishbone_data_i = $urandom;
    #1;
    check_wb(tag, 1'b0, 1'b0, '0, '0, '0);
    check({tag, ".stall"}, stall_req_o, 1'b0);
    check({tag, ".rdata"}, cpu_data_o, '0);
    check({tag, ".err"},   bus_err_o, 1'b0);
  endtask

  // Launch cycle: request presented in IDLE; a stray ack here must be ignored.
  task automatic launch_only(input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [SW-1:0] sel);
    @(negedge clk);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata;
    cpu_sel_i = sel; flush_i = 1'b0; cpu_stall_i = 1'b0;
    wishbone_ack_i = 1'($urandom_range(0, 1)); wishbone_data_i = $urandom;
    #1;
    check("launch.stall", stall_req_o, 1'b1);
    check("launch.rdata", cpu_data_o, '0);
    check_wb("launch", 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One full request. d = BUSY cycle carrying the ack (>=1), f = BUSY cycle
  // carrying flush (0 = none), s = extra cycles the pipeline stays held after
  // the ack (0 = release in the ack cycle).
  task automatic do_txn(input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                        input logic [SW-1:0] sel, input int d, input int s, input int f);
    logic [DW-1:0] exp_rd;
    bit flushed;
    exp_rd  = we ? '0 : rdata;
    flushed = (f != 0) && (f <= d);
    launch_only(we, addr, wdata, sel);
    for (int i = 1; i <= d; i++) begin
      @(negedge clk);
      wishbone_ack_i  = (i == d);
      flush_i         = (f != 0) && (i == f);
      cpu_stall_i     = (i == d) && (s > 0);
      wishbone_data_i = (i == d) ? rdata : DW'($urandom);
      #1;
      check_wb("busy", 1'b1, we, addr, wdata, sel);
      check("busy.err", bus_err_o, 1'b0);
      if (flush_i) begin
        check("flush.stall", stall_req_o, 1'b0);
        check("flush.rdata", cpu_data_o, '0);
        break;
      end else if (wishbone_ack_i) begin
        check("ack.stall", stall_req_o, 1'b0);
        check("ack.rdata", cpu_data_o, exp_rd);
      end else begin
        check("wait.stall", stall_req_o, 1'b1);
        check("wait.rdata", cpu_data_o, '0);
      end
    end
    if (flushed) begin
      idle_cycle("postflush", 1'b1);
    end else begin
      for (int j = 1; j <= s; j++) begin
        @(negedge clk);
        cpu_ce_i = 1'b0; flush_i = 1'b0; cpu_stall_i = (j < s);
        wishbone_ack_i = 1'($urandom_range(0, 1)); wishbone_data_i = $urandom;
        #1;
        check_wb("hold", 1'b0, 1'b0, '0, '0, '0);
        check("hold.stall", stall_req_o, 1'b0);
        if (!we) check("hold.rdata", cpu_data_o, rdata);
      end
    end
    idle_cycle("idle", 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check_wb("reset", 1'b0, 1'b0, '0, '0, '0);
    check("reset.rdata", cpu_data_o, '0);
    check("reset.stall", stall_req_o, 1'b0);
    check("reset.err",   bus_err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_txn(1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 4'hF, 1, 0, 0);          // read
    do_txn(1'b1, 32'h0000_0200, 32'h1234_5678, 32'hA5A5_5A5A, 4'b0011, 1, 0, 0); // write
    do_txn(1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 4'hF, 1, 3, 0);          // stalled read
    do_txn(1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 4'hF, 2, 0, 2);          // flush + ack

    // Randomised transactions
    for (int n = 0; n < 60; n++) begin
      int d, s, f;
      d = $urandom_range(1, 5);
      s = $urandom_range(0, 3);
      f = ($urandom_range(0, 4) == 0) ? $urandom_range(1, d) : 0;
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             SW'($urandom), d, s, f);
    end

`ifdef WB_MASTER_TIMEOUT_EN
    // No ack: abort in the TMO-th BUSY cycle with a single error pulse.
    launch_only(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      cpu_ce_i = (i < TMO); wishbone_ack_i = 1'b0; wishbone_data_i = $urandom;
      #1;
      check_wb("tmo.busy", 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
      check("tmo.err",   bus_err_o,   (i == TMO));
      check("tmo.stall", stall_req_o, (i != TMO));
      check("tmo.rdata", cpu_data_o,  '0);
    end
    idle_cycle("tmo.after", 1'b1);
    // Fresh request to be interrupted by reset.
    launch_only(1'b0, 32'h0000_0500, 32'h0, 4'hF);
    @(negedge clk);
    wishbone_ack_i = 1'b0;
    #1;
    check("rst.pre.cyc", wishbone_cyc_o, 1'b1);
`else
    // No ack: the cycle is held indefinitely and no error is ever raised.
    launch_only(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      wishbone_ack_i = 1'b0; wishbone_data_i = $urandom;
      #1;
      check("hang.cyc",   wishbone_cyc_o, 1'b1);
      check("hang.err",   bus_err_o,      1'b0);
      check("hang.stall", stall_req_o,    1'b1);
    end
`endif

    // Reset mid-BUSY: outputs must drop before the next rising edge.
    #1;
    rst_n = 1'b0; cpu_ce_i = 1'b0;
    #1;
    check_wb("midrst", 1'b0, 1'b0, '0, '0, '0);
    check("midrst.rdata", cpu_data_o, '0);
    check("midrst.stall", stall_req_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 4'hF, 2, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
